// File: rtl/ex_pkg.sv
// Shared opcodes, result classes and divider state encoding for the EX stage.
package ex_pkg;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BUSY    = 2'b01,
    DIV_END     = 2'b10,
    DIV_BY_ZERO = 2'b11
  } div_state_t;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_div.sv
// Restoring shift-subtract divider, one quotient bit per cycle, signed fix-up on output.
//   state       | meaning
//   DIV_FREE    | idle, waiting for start
//   DIV_BUSY    | iterating, one shift-subtract step per cycle
//   DIV_END     | result valid for one cycle
//   DIV_BY_ZERO | divisor was zero, result forced to 0 for one cycle
module ex_div
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);

  localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

  div_state_t  state, state_next;
  logic [64:0] dividend;
  logic [31:0] divisor;
  logic [5:0]  cnt;
  logic        neg_q, neg_r;

  logic        op1_neg, op2_neg;
  logic [31:0] mag1, mag2;
  logic [32:0] sub;
  logic [31:0] quot, rem;

  assign op1_neg = signed_div & opdata1[31];
  assign op2_neg = signed_div & opdata2[31];
  assign mag1    = op1_neg ? (32'd0 - opdata1) : opdata1;
  assign mag2    = op2_neg ? (32'd0 - opdata2) : opdata2;
  assign sub     = {1'b0, dividend[63:32]} - {1'b0, divisor};

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_FREE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_FREE: begin
        if (start && !annul)
          state_next = (opdata2 == 32'd0) ? DIV_BY_ZERO : DIV_BUSY;
      end
      DIV_BUSY:    if (cnt == LAST_STEP) state_next = DIV_END;
      DIV_END:     state_next = DIV_FREE;
      DIV_BY_ZERO: state_next = DIV_FREE;
      default:     state_next = DIV_FREE;
    endcase
    if (annul) state_next = DIV_FREE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dividend <= '0;
      divisor  <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (state == DIV_FREE) begin
      if (start && !annul && opdata2 != 32'd0) begin
        dividend <= {32'd0, mag1, 1'b0};
        divisor  <= mag2;
        cnt      <= '0;
        neg_q    <= op1_neg ^ op2_neg;
        neg_r    <= op1_neg;
      end
    end else if (state == DIV_BUSY && !annul) begin
      // Borrow out means the partial remainder was too small: shift in a 0 quotient bit.
      if (sub[32]) dividend <= {dividend[63:0], 1'b0};
      else         dividend <= {sub[31:0], dividend[31:0], 1'b1};
      cnt <= cnt + 6'd1;
    end
  end

  assign quot  = neg_q ? (32'd0 - dividend[31:0])  : dividend[31:0];
  assign rem   = neg_r ? (32'd0 - dividend[64:33]) : dividend[64:33];

  assign result = (state == DIV_END) ? {rem, quot} : 64'd0;
  assign ready  = (state == DIV_END) || (state == DIV_BY_ZERO);

endmodule

// File: rtl/ex.sv
// OpenMIPS execute stage: combinational ALU plus a multi-cycle divider that stalls the pipe.
module ex
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o
);

  logic [31:0] logic_res, shift_res, arith_res, alu_res;
  logic        div_op;
  logic [63:0] div_result;
  logic        div_ready;

  assign div_op = is_div_op(aluop_i);

  ex_div #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_op),
    .signed_div (aluop_i == EXE_DIV_OP),
    .opdata1    (reg1_i),
    .opdata2    (reg2_i),
    .annul      (flush_i),
    .result     (div_result),
    .ready      (div_ready)
  );

  always_comb begin
    logic_res = 32'd0;
    shift_res = 32'd0;
    arith_res = 32'd0;
    case (aluop_i)
      EXE_OR_OP:   logic_res = reg1_i | reg2_i;
      EXE_AND_OP:  logic_res = reg1_i & reg2_i;
      EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
      EXE_SLL_OP:  shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP:  shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP:  shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
      EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      EXE_SLTU_OP: arith_res = {31'd0, reg1_i < reg2_i};
      default: ;
    endcase
  end

  always_comb begin
    case (alusel_i)
      EXE_RES_LOGIC: alu_res = logic_res;
      EXE_RES_SHIFT: alu_res = shift_res;
      EXE_RES_ARITH: alu_res = arith_res;
      default:       alu_res = 32'd0;
    endcase
  end

  // Reset gates every output so a division in flight cannot leak a stall or HI/LO write.
  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    hi_o       = 32'd0;
    lo_o       = 32'd0;
    whilo_o    = 1'b0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i & ~div_op;
      wdata_o    = alu_res;
      hi_o       = div_result[63:32];
      lo_o       = div_result[31:0];
      whilo_o    = div_ready;
      stallreq_o = div_op & ~div_ready & ~flush_i;
    end
  end

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage OpenMIPS pipeline. Consumes the decoded operation (`aluop_i`, `alusel_i`, `reg1_i`, `reg2_i`, `wd_i`, `wreg_i`) from the ID/EX pipeline register. Produces the GPR write-back triple and the HI/LO write request for EX/MEM. Single-cycle ALU ops complete combinationally. DIV/DIVU run on an internal 32-iteration sequential divider and hold the pipeline via `stallreq_o`.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: divider iterations; fixed at 32 for this release.

Ports:
- `clk` in 1: pipeline clock.
- `rst` in 1: reset, synchronous, active-high (`Enable`).
- `aluop_i` in 8 (`AluOpBus`): operation code from ID.
- `alusel_i` in 3 (`AluSelBus`): result class (LOGIC/SHIFT/ARITH/NOP).
- `reg1_i`, `reg2_i` in 32 each: operands (register data or zero-extended immediate).
- `wd_i` in 5: destination GPR.
- `wreg_i` in 1: GPR write enable.
- `flush_i` in 1: cancels an in-flight division.
- `wd_o` out 5: destination GPR.
- `wreg_o` out 1: GPR write enable.
- `wdata_o` out 32: write-back data.
- `hi_o`, `lo_o` out 32 each: HI/LO write data.
- `whilo_o` out 1: HI/LO write enable.
- `stallreq_o` out 1: request to hold PC, IF/ID and ID/EX.

## Operation
- Logic: OR, AND, XOR, NOR on `reg1_i`/`reg2_i`.
- Shift: SLL, SRL, SRA of `reg2_i` by `reg1_i[4:0]`.
- Arithmetic: ADDU, SUBU (mod 2^32, no overflow trap); SLT (signed compare), SLTU (unsigned compare), each giving 32'd1 or 32'd0.
- `wdata_o` is selected by `alusel_i`. NOP class or unknown op gives 0.
- `wd_o` equals `wd_i`; `wreg_o` equals `wreg_i`.
- DIV/DIVU: `wreg_o`=0; quotient goes to `lo_o`, remainder to `hi_o`, written via `whilo_o`.
- Divider FSM states: IDLE, BUSY, DONE, DIVZERO.
  - IDLE → BUSY when a div op is present, `reg2_i`≠0 and `flush_i`=0. The FSM latches operand magnitudes, the sign flags and the op type, and clears the count.
  - IDLE → DIVZERO when a div op is present with `reg2_i`=0.
  - BUSY: one restoring shift-subtract step per cycle, count +1. After the 32nd step → DONE.
  - DONE / DIVZERO → IDLE unconditionally on the next edge.
  - `flush_i`=1 in any state → IDLE.
- Signed DIV fix-up: quotient is negated if the operand signs differ; remainder takes the dividend's sign. DIVU uses raw operands.
- DIVZERO result: `hi_o`=`lo_o`=0, `whilo_o`=1, no trap.
- `stallreq_o`=1 when a div op is present and the state is IDLE or BUSY. Otherwise 0.
- `whilo_o`=1 only in DONE or DIVZERO.

## Timing
- Reset: all outputs 0, FSM IDLE, divider registers 0. Reset mid-division gives IDLE on the next edge with `stallreq_o`=0.
- Non-div ops: zero latency, purely combinational from inputs.
- Division with nonzero divisor, div op arriving in cycle 0:
  - `stallreq_o`=1 in cycles 0..32; BUSY during cycles 1..32.
  - Cycle 33 is DONE: `stallreq_o`=0, `whilo_o`=1, result valid; ID/EX advances on that edge.
  - Total 34 cycles.
- Division by zero: cycle 0 stalls, cycle 1 is DIVZERO with the result; 2 cycles total.
- Upstream holds the inputs stable while `stallreq_o`=1. The latched operands are authoritative during BUSY.
- `flush_i` together with a div op in IDLE: no start, `stallreq_o` forced 0.
- Back-to-back divisions: the second starts from IDLE the cycle after DONE.

## Structure
- `defines.v` gains:
  - `EXE_DIV_OP`, `EXE_DIVU_OP`, `EXE_SLT_OP`, `EXE_SLTU_OP`, `EXE_ADDU_OP`, `EXE_SUBU_OP`, `EXE_SLL_OP`, `EXE_SRL_OP`, `EXE_SRA_OP`, `EXE_AND_OP`, `EXE_XOR_OP`, `EXE_NOR_OP`;
  - `EXE_RES_SHIFT`, `EXE_RES_ARITH`;
  - divider state encodings `DivFree`, `DivBusy`, `DivEnd`, `DivByZero`.
- One sub-module, `div`: FSM plus 65-bit dividend/remainder shift register and 6-bit counter. Interface: start, signed, opdata1, opdata2, annul → result[63:0], ready. `ex` wraps it with the ALU muxes and stall logic.

## Test plan
- ORI result: aluop OR, `reg1_i`=32'h0000_1100, `reg2_i`=32'h0000_0020, `wd_i`=5, `wreg_i`=1 → same cycle `wdata_o`=32'h0000_1120, `wd_o`=5, `wreg_o`=1, `stallreq_o`=0.
- SRA: `reg2_i`=32'h8000_0000, `reg1_i`=4 → `wdata_o`=32'hF800_0000. SLT with -1 vs 1 → 1; SLTU with the same operands → 0.
- DIV signed: -7 ÷ 2 → `stallreq_o` high 33 cycles, then one cycle with `lo_o`=32'hFFFF_FFFD (-3), `hi_o`=32'hFFFF_FFFF (-1), `whilo_o`=1.
- DIVU by zero: 100 ÷ 0 → stall 1 cycle, next cycle `hi_o`=`lo_o`=0, `whilo_o`=1.
- `flush_i` at BUSY step 10 → IDLE next cycle, `whilo_o` never asserted, `stallreq_o`=0 once the op is removed.
- `rst`=1 during BUSY → all outputs 0 next cycle. A fresh DIVU 32'hFFFF_FFFF ÷ 16 then gives `lo_o`=32'h0FFF_FFFF, `hi_o`=15.
